// File: rtl/forthsuper_pkg.sv
// Types shared between the Forth core stack and the ALU decoder.
package forthsuper_pkg;

    typedef enum logic [2:0] {
        NOP  = 3'd0,
        PUSH = 3'd1,
        POP  = 3'd2,
        REPL = 3'd3,
        SWAP = 3'd4,
        PICK = 3'd5
    } stack_op_e;

    typedef enum logic [0:0] {
        StIdle  = 1'b0,
        StFetch = 1'b1
    } pick_state_e;

endpackage

// File: rtl/stack_ram.sv
// Behavioural model of the 1R1W EBR that holds stack cells below NOS.
// Sync write, sync read, write-first bypass; en freezes both ports.
module stack_ram #(
    parameter int unsigned WORDS = 62,
    parameter int unsigned DSZ   = 32,
    parameter int unsigned ASZ   = 6
) (
    input  logic           clk,
    input  logic           en,
    input  logic           we,
    input  logic [ASZ-1:0] waddr,
    input  logic [DSZ-1:0] wdata,
    input  logic [ASZ-1:0] raddr,
    output logic [DSZ-1:0] rdata
);

    logic [DSZ-1:0] mem [WORDS];

    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                mem[waddr] <= wdata;
            end
            if (we && (waddr == raddr)) begin
                rdata <= wdata;
            end else if (32'(raddr) < WORDS) begin
                // raddr points past the array only when the stack is too shallow to care
                rdata <= mem[raddr];
            end
        end
    end

endmodule

// File: rtl/tos_stack.sv
// FILO data/return stack: TOS/NOS in registers, deeper cells in stack_ram.
// Supports PUSH/POP/REPL/SWAP/PICK with sticky error and busy for deep PICK.
module tos_stack
    import forthsuper_pkg::*;
#(
    parameter int unsigned DEPTH = 64,
    parameter int unsigned DSZ   = 32,
    parameter int unsigned SSZ   = $clog2(DEPTH)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           en,
    input  stack_op_e      op,
    input  logic [DSZ-1:0] vi,
    input  logic [SSZ-1:0] idx,
    output logic [DSZ-1:0] t,
    output logic [DSZ-1:0] s,
    output logic [SSZ:0]   depth,
    output logic           empty,
    output logic           full,
    output logic           err,
    output logic           busy
);

    typedef logic [SSZ-1:0] ptr_t;
    typedef logic [SSZ:0]   cnt_t;

    logic [DSZ-1:0] t_q, t_d, s_q, s_d;
    ptr_t           rp_q, rp_d;
    cnt_t           depth_q, depth_d;
    logic           err_q, err_d;
    pick_state_e    state_q, state_d;

    logic           we;
    logic           do_push;
    logic           pick_far;
    logic [DSZ-1:0] push_val;
    ptr_t           raddr;
    logic [DSZ-1:0] third;
    logic           is_empty, is_full;

    assign is_empty = (depth_q == '0);
    assign is_full  = (depth_q == cnt_t'(DEPTH));

    always_comb begin
        t_d      = t_q;
        s_d      = s_q;
        rp_d     = rp_q;
        depth_d  = depth_q;
        err_d    = err_q;
        state_d  = state_q;
        we       = 1'b0;
        do_push  = 1'b0;
        pick_far = 1'b0;
        push_val = '0;

        if (rst) begin
            t_d     = '0;
            s_d     = '0;
            rp_d    = '0;
            depth_d = '0;
            err_d   = 1'b0;
            state_d = StIdle;
        end else if (en) begin
            if (state_q == StFetch) begin
                do_push  = 1'b1;
                push_val = third;
                state_d  = StIdle;
            end else begin
                unique case (op)
                    PUSH: begin
                        if (is_full) begin
                            err_d = 1'b1;
                        end else begin
                            do_push  = 1'b1;
                            push_val = vi;
                        end
                    end
                    POP: begin
                        if (is_empty) begin
                            err_d = 1'b1;
                        end else begin
                            t_d     = s_q;
                            depth_d = depth_q - cnt_t'(1);
                            if (depth_q > cnt_t'(2)) begin
                                s_d  = third;
                                rp_d = rp_q - ptr_t'(1);
                            end else begin
                                s_d = '0;
                            end
                        end
                    end
                    REPL: begin
                        if (is_empty) err_d = 1'b1;
                        else          t_d   = vi;
                    end
                    SWAP: begin
                        if (depth_q < cnt_t'(2)) begin
                            err_d = 1'b1;
                        end else begin
                            t_d = s_q;
                            s_d = t_q;
                        end
                    end
                    PICK: begin
                        if (is_full || (cnt_t'(idx) >= depth_q)) begin
                            err_d = 1'b1;
                        end else if (idx == ptr_t'(0)) begin
                            do_push  = 1'b1;
                            push_val = t_q;
                        end else if (idx == ptr_t'(1)) begin
                            do_push  = 1'b1;
                            push_val = s_q;
                        end else begin
                            pick_far = 1'b1;
                            state_d  = StFetch;
                        end
                    end
                    default: ;
                endcase
            end

            if (do_push) begin
                s_d     = t_q;
                t_d     = push_val;
                depth_d = depth_q + cnt_t'(1);
                if (depth_q >= cnt_t'(2)) begin
                    we   = 1'b1;
                    rp_d = rp_q + ptr_t'(1);
                end
            end
        end
    end

    // Read port normally tracks the next third cell; a deep PICK borrows it for one cycle.
    assign raddr = pick_far ? (rp_q + ptr_t'(1) - idx) : (rp_d - ptr_t'(1));

    always_ff @(posedge clk) begin
        t_q     <= t_d;
        s_q     <= s_d;
        rp_q    <= rp_d;
        depth_q <= depth_d;
        err_q   <= err_d;
        state_q <= state_d;
    end

    stack_ram #(
        .WORDS(DEPTH - 2),
        .DSZ  (DSZ),
        .ASZ  (SSZ)
    ) u_ram (
        .clk  (clk),
        .en   (en),
        .we   (we),
        .waddr(rp_q),
        .wdata(s_q),
        .raddr(raddr),
        .rdata(third)
    );

    assign t     = t_q;
    assign s     = s_q;
    assign depth = depth_q;
    assign empty = is_empty;
    assign full  = is_full;
    assign err   = err_q;
    assign busy  = (state_q == StFetch);

endmodule

// File: tb/tb_tos_stack.sv
// Directed self-checking bench for tos_stack with hand-computed expectations.
module tb_tos_stack;
    import forthsuper_pkg::*;

    localparam int unsigned DEPTH = 64;
    localparam int unsigned DSZ   = 32;
    localparam int unsigned SSZ   = 6;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           en  = 1'b1;
    stack_op_e      op  = NOP;
    logic [DSZ-1:0] vi  = '0;
    logic [SSZ-1:0] idx = '0;
    logic [DSZ-1:0] t, s;
    logic [SSZ:0]   depth;
    logic           empty, full, err, busy;

    int passed = 0;
    int total  = 0;

    tos_stack #(
        .DEPTH(DEPTH),
        .DSZ  (DSZ),
        .SSZ  (SSZ)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .en   (en),
        .op   (op),
        .vi   (vi),
        .idx  (idx),
        .t    (t),
        .s    (s),
        .depth(depth),
        .empty(empty),
        .full (full),
        .err  (err),
        .busy (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step(input stack_op_e o, input logic [DSZ-1:0] v, input logic [SSZ-1:0] i);
        op  = o;
        vi  = v;
        idx = i;
        @(posedge clk);
        #1;
        op  = NOP;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        // Reset state
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_t", t, 0);
        check("rst_s", s, 0);
        check("rst_depth", depth, 0);
        check("rst_empty", empty, 1);
        check("rst_full", full, 0);
        check("rst_err", err, 0);
        check("rst_busy", busy, 0);

        // 1. reset aborts an in-flight PICK
        step(PUSH, 10, 0);
        step(PUSH, 20, 0);
        step(PUSH, 30, 0);
        step(PICK, 0, 2);
        check("t1_busy_set", busy, 1);
        do_reset();
        check("t1_busy", busy, 0);
        check("t1_depth", depth, 0);
        check("t1_t", t, 0);
        check("t1_s", s, 0);
        check("t1_err", err, 0);

        // 2. push four, pop three back-to-back
        step(PUSH, 1, 0);
        step(PUSH, 2, 0);
        step(PUSH, 3, 0);
        step(PUSH, 4, 0);
        check("t2_t4", t, 4);
        check("t2_s3", s, 3);
        check("t2_d4", depth, 4);
        step(POP, 0, 0);
        check("t2_pop1_t", t, 3);
        check("t2_pop1_s", s, 2);
        step(POP, 0, 0);
        check("t2_pop2_t", t, 2);
        check("t2_pop2_s", s, 1);
        step(POP, 0, 0);
        check("t2_pop3_t", t, 1);
        check("t2_pop3_s", s, 0);
        check("t2_pop3_d", depth, 1);
        check("t2_err", err, 0);

        // 3. fill to capacity, overflow, then drain
        do_reset();
        for (int k = 1; k <= DEPTH; k++) step(PUSH, k, 0);
        check("t3_full", full, 1);
        check("t3_depth", depth, DEPTH);
        check("t3_t", t, DEPTH);
        step(PUSH, 99, 0);
        check("t3_ovf_err", err, 1);
        check("t3_ovf_t", t, DEPTH);
        check("t3_ovf_s", s, DEPTH - 1);
        check("t3_ovf_depth", depth, DEPTH);
        for (int k = 1; k <= DEPTH; k++) begin
            step(POP, 0, 0);
            check("t3_drain_t", t, DEPTH - k);
        end
        check("t3_empty", empty, 1);

        // 4. underflow then reset clears err
        do_reset();
        step(POP, 0, 0);
        check("t4_unf_err", err, 1);
        check("t4_unf_depth", depth, 0);
        do_reset();
        check("t4_err_clr", err, 0);

        // 5. deep PICK, busy ignores op, PICK out of range
        step(PUSH, 10, 0);
        step(PUSH, 20, 0);
        step(PUSH, 30, 0);
        step(PUSH, 40, 0);
        step(PICK, 0, 3);
        check("t5_busy", busy, 1);
        check("t5_busy_t", t, 40);
        check("t5_busy_d", depth, 4);
        step(PUSH, 77, 0);
        check("t5_done_busy", busy, 0);
        check("t5_t", t, 10);
        check("t5_s", s, 40);
        check("t5_d", depth, 5);
        step(PICK, 0, 5);
        check("t5_range_err", err, 1);
        check("t5_range_d", depth, 5);
        check("t5_range_busy", busy, 0);
        step(PICK, 0, 1);
        check("t5_pick1_t", t, 40);
        check("t5_pick1_s", s, 10);
        check("t5_pick1_d", depth, 6);
        step(POP, 0, 0);
        step(POP, 0, 0);
        check("t5_pop_t", t, 40);
        check("t5_pop_s", s, 30);

        // 6. push/pop bypass, SWAP, REPL, en hold
        do_reset();
        step(PUSH, 1, 0);
        step(PUSH, 2, 0);
        step(PUSH, 3, 0);
        step(PUSH, 7, 0);
        step(POP, 0, 0);
        check("t6_byp_t", t, 3);
        check("t6_byp_s", s, 2);
        do_reset();
        step(PUSH, 5, 0);
        step(SWAP, 0, 0);
        check("t6_swap1_err", err, 1);
        check("t6_swap1_t", t, 5);
        do_reset();
        step(PUSH, 5, 0);
        step(PUSH, 6, 0);
        step(SWAP, 0, 0);
        check("t6_swap_t", t, 5);
        check("t6_swap_s", s, 6);
        step(REPL, 55, 0);
        check("t6_repl_t", t, 55);
        check("t6_repl_s", s, 6);
        en = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step(POP, 0, 0);
            check("t6_hold_t", t, 55);
            check("t6_hold_s", s, 6);
            check("t6_hold_d", depth, 2);
        end
        en = 1'b1;
        step(PUSH, 8, 0);
        step(PICK, 0, 2);
        check("t6_pick_busy", busy, 1);
        en = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step(NOP, 0, 0);
            check("t6_fetch_hold", busy, 1);
        end
        en = 1'b1;
        step(NOP, 0, 0);
        check("t6_pick_t", t, 6);
        check("t6_pick_s", s, 8);
        check("t6_pick_d", depth, 4);
        check("t6_err", err, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
